// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared datapath widths and types for the single-cycle CPU
package cpu_pkg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int NREG   = 2 ** ADDR_W;
  localparam int CNT_W  = 16;

  localparam logic [ADDR_W-1:0] REG_ZERO = 5'd0;

  typedef logic [DATA_W-1:0] word_t;

endpackage

// File: rtl/dec5to32.sv
// rtl/dec5to32.sv - write-enable demux: index to one-hot, all-zero when disabled
module dec5to32 #(
  parameter int AW = cpu_pkg::ADDR_W
) (
  input  logic              wr_en,
  input  logic [AW-1:0]     addr,
  output logic [2**AW-1:0]  onehot
);

  always_comb begin
    onehot = '0;
    if (wr_en) begin
      onehot[addr] = 1'b1;
    end
  end

endmodule

// File: rtl/reg_file_wr_demux32.sv
// rtl/reg_file_wr_demux32.sv - 32-entry register file, one demuxed write port, two comb read ports
// Register 0 is hard-wired to zero; BYPASS forwards the in-flight write word to matching reads.
module reg_file_wr_demux32 #(
  parameter int DATA_W = cpu_pkg::DATA_W,
  parameter int ADDR_W = cpu_pkg::ADDR_W,
  parameter bit BYPASS = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wr_en,
  input  logic [ADDR_W-1:0]    wr_addr,
  input  logic [DATA_W-1:0]    wr_data,
  input  logic [ADDR_W-1:0]    rd_addr_a,
  input  logic [ADDR_W-1:0]    rd_addr_b,
  output logic [DATA_W-1:0]    rd_data_a,
  output logic [DATA_W-1:0]    rd_data_b,
  output logic [2**ADDR_W-1:0] wr_onehot_q,
  output logic [15:0]          wr_count_q
);

  localparam int NREG = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] ZERO_IDX = ADDR_W'(cpu_pkg::REG_ZERO);

  logic [NREG-1:0]   dec_onehot;
  logic [NREG-1:0]   wr_sel;
  logic              commit;
  logic [DATA_W-1:0] mem_q [NREG];
  logic [DATA_W-1:0] mem_d [NREG];
  logic [NREG-1:0]   wr_onehot_d;
  logic [15:0]       wr_count_d;
  logic              hit_a;
  logic              hit_b;

  dec5to32 #(
    .AW (ADDR_W)
  ) u_dec (
    .wr_en  (wr_en),
    .addr   (wr_addr),
    .onehot (dec_onehot)
  );

  // Bit 0 is masked so a write to the zero register never commits.
  assign wr_sel = {dec_onehot[NREG-1:1], 1'b0};
  assign commit = |wr_sel;

  always_comb begin
    for (int i = 0; i < NREG; i++) begin
      mem_d[i] = mem_q[i];
      if (wr_sel[i]) begin
        mem_d[i] = wr_data;
      end
    end
    mem_d[0] = '0;
  end

  always_comb begin
    wr_onehot_d = wr_sel;
    wr_count_d  = wr_count_q + 16'(commit);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) begin
        mem_q[i] <= '0;
      end
      wr_onehot_q <= '0;
      wr_count_q  <= '0;
    end else begin
      for (int i = 0; i < NREG; i++) begin
        mem_q[i] <= mem_d[i];
      end
      wr_onehot_q <= wr_onehot_d;
      wr_count_q  <= wr_count_d;
    end
  end

  always_comb begin
    hit_a = BYPASS && commit && (rd_addr_a == wr_addr);
    hit_b = BYPASS && commit && (rd_addr_b == wr_addr);
  end

  // Reset forces zero even when a bypass would otherwise forward wr_data.
  always_comb begin
    rd_data_a = '0;
    rd_data_b = '0;
    if (!rst) begin
      if (rd_addr_a != ZERO_IDX) begin
        rd_data_a = hit_a ? wr_data : mem_q[rd_addr_a];
      end
      if (rd_addr_b != ZERO_IDX) begin
        rd_data_b = hit_b ? wr_data : mem_q[rd_addr_b];
      end
    end
  end

endmodule
